// File: rtl/tetris_pkg.sv
// tetris_pkg: types and constants shared by the action scheduling logic.
//   action_t      - action code offered to the movement/collision datapath
//   sched_state_t - scheduler FSM state encoding (StIdle, StIssue, StWaitDone)
//   P_*           - bit positions in the pending mask {hold,drop,rotate,right,left,down}
//   act_bit()     - maps an action code to its pending-mask bit (none for GRAVITY/NONE)
package tetris_pkg;

   typedef enum logic [2:0] {
      ActNone    = 3'd0,
      ActLeft    = 3'd1,
      ActRight   = 3'd2,
      ActDown    = 3'd3,
      ActRotate  = 3'd4,
      ActDrop    = 3'd5,
      ActHold    = 3'd6,
      ActGravity = 3'd7
   } action_t;

   typedef logic [1:0] sched_state_t;
   localparam sched_state_t StIdle     = 2'd0;
   localparam sched_state_t StIssue    = 2'd1;
   localparam sched_state_t StWaitDone = 2'd2;

   localparam int unsigned P_DOWN   = 0;
   localparam int unsigned P_LEFT   = 1;
   localparam int unsigned P_RIGHT  = 2;
   localparam int unsigned P_ROTATE = 3;
   localparam int unsigned P_DROP   = 4;
   localparam int unsigned P_HOLD   = 5;

   // Moves that become stale once the piece is dropped or swapped out.
   localparam logic [5:0] MOVE_MASK = 6'b001111;

   function automatic logic [5:0] act_bit(input action_t a);
      logic [5:0] m;
      m = '0;
      case (a)
         ActDown:   m[P_DOWN]   = 1'b1;
         ActLeft:   m[P_LEFT]   = 1'b1;
         ActRight:  m[P_RIGHT]  = 1'b1;
         ActRotate: m[P_ROTATE] = 1'b1;
         ActDrop:   m[P_DROP]   = 1'b1;
         ActHold:   m[P_HOLD]   = 1'b1;
         default:   m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/action_prio_enc.sv
// action_prio_enc: combinational fixed-priority pick of the next action.
//   pend_mask - pending {hold,drop,rotate,right,left,down}
//   grav_nz   - at least one gravity step pending
//   winner    - highest-priority pending action, ActNone if nothing pending
module action_prio_enc
   import tetris_pkg::*;
(
   input  logic [5:0] pend_mask,
   input  logic       grav_nz,
   output action_t    winner
);

   always_comb begin
      winner = ActNone;
      if (pend_mask[P_HOLD])        winner = ActHold;
      else if (pend_mask[P_DROP])   winner = ActDrop;
      else if (pend_mask[P_ROTATE]) winner = ActRotate;
      else if (pend_mask[P_LEFT])   winner = ActLeft;
      else if (pend_mask[P_RIGHT])  winner = ActRight;
      else if (pend_mask[P_DOWN])   winner = ActDown;
      else if (grav_nz)             winner = ActGravity;
   end

endmodule

// File: rtl/action_scheduler.sv
// action_scheduler: latches command pulses into a pending set, counts gravity ticks and
// issues one action at a time to the datapath over valid/ready, then waits for done.
//   clk, rst_n          - clock, asynchronous active-low reset
//   enable              - game running; low withdraws an offer and flushes pending state
//   cmd_*, tick_gravity - one-cycle request pulses
//   act_ready, act_done - datapath accept / completion pulse
//   act_valid, act_code - offered action
//   busy                - FSM not idle
//   pend_mask, grav_pend- registered pending set and gravity count
//   err_timeout         - sticky flag: datapath never signalled done
module action_scheduler
   import tetris_pkg::*;
#(
   parameter int unsigned GRAV_MAX     = 3,
   parameter int unsigned GRAV_W       = 2,
   parameter int unsigned DONE_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              cmd_left,
   input  logic              cmd_right,
   input  logic              cmd_down,
   input  logic              cmd_rotate,
   input  logic              cmd_drop,
   input  logic              cmd_hold,
   input  logic              tick_gravity,
   input  logic              act_ready,
   input  logic              act_done,
   output logic              act_valid,
   output logic [2:0]        act_code,
   output logic              busy,
   output logic [5:0]        pend_mask,
   output logic [GRAV_W-1:0] grav_pend,
   output logic              err_timeout
);

   localparam int unsigned TO_W = $clog2(DONE_TIMEOUT + 1);

   sched_state_t      state_q, state_d;
   logic [5:0]        pend_q, pend_d;
   logic [GRAV_W-1:0] grav_q, grav_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   action_t           code_q, code_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;

   action_t    winner;
   logic       grav_nz;
   logic       accept;
   logic       grav_dec;
   logic [5:0] set_m, clr_m;

   assign grav_nz = (grav_q != '0);
   assign accept  = (state_q == StIssue) && enable && act_ready;
   assign grav_dec = accept && (code_q == ActGravity);

   action_prio_enc u_prio (
      .pend_mask (pend_q),
      .grav_nz   (grav_nz),
      .winner    (winner)
   );

   // Pending set: clears first, then sets, so a coinciding set always wins.
   always_comb begin
      set_m = '0;
      clr_m = '0;
      set_m[P_DOWN]   = cmd_down;
      set_m[P_ROTATE] = cmd_rotate;
      set_m[P_DROP]   = cmd_drop;
      set_m[P_HOLD]   = cmd_hold;
      // Opposite directions cancel rather than queue up.
      if (cmd_left && !cmd_right) begin
         if (pend_q[P_RIGHT]) clr_m[P_RIGHT] = 1'b1;
         else                 set_m[P_LEFT]  = 1'b1;
      end
      if (cmd_right && !cmd_left) begin
         if (pend_q[P_LEFT]) clr_m[P_LEFT]  = 1'b1;
         else                set_m[P_RIGHT] = 1'b1;
      end
      if (accept) begin
         clr_m = clr_m | act_bit(code_q);
         if (code_q == ActDrop || code_q == ActHold) clr_m = clr_m | MOVE_MASK;
      end
      pend_d = enable ? ((pend_q & ~clr_m) | set_m) : '0;
   end

   always_comb begin
      grav_d = grav_q;
      if (!enable) begin
         grav_d = '0;
      end else if (accept && code_q == ActDrop) begin
         // Piece locks: old gravity is moot, a tick in this very cycle still counts.
         grav_d = tick_gravity ? GRAV_W'(1) : '0;
      end else if (tick_gravity && !grav_dec) begin
         if (grav_q != GRAV_W'(GRAV_MAX)) grav_d = grav_q + GRAV_W'(1);
      end else if (grav_dec && !tick_gravity) begin
         grav_d = grav_q - GRAV_W'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      valid_d  = valid_q;
      to_cnt_d = to_cnt_q;
      err_d    = err_q;
      case (state_q)
         StIdle: begin
            if (enable && winner != ActNone) begin
               code_d  = winner;
               valid_d = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (!enable) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end else if (act_ready) begin
               valid_d  = 1'b0;
               to_cnt_d = '0;
               state_d  = StWaitDone;
            end
         end
         StWaitDone: begin
            if (act_done) begin
               state_d = StIdle;
            end else if (to_cnt_q == TO_W'(DONE_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         pend_q   <= '0;
         grav_q   <= '0;
         to_cnt_q <= '0;
         code_q   <= ActNone;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         grav_q   <= grav_d;
         to_cnt_q <= to_cnt_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
      end
   end

   assign act_valid   = valid_q;
   assign act_code    = code_q;
   assign busy        = (state_q != StIdle);
   assign pend_mask   = pend_q;
   assign grav_pend   = grav_q;
   assign err_timeout = err_q;

endmodule
